// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: program counter, instruction register and instruction-type decode.
// Optional macro FETCH_BRANCH_EN enables Bcond/Jcond target evaluation; otherwise the PC only increments.
module fetch_decode_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic              ir_en,
    input  logic [15:0]       mem_rdata,
    input  logic [4:0]        flags,
    input  logic [15:0]       jtarget,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       ir,
    output logic [1:0]        instr_type,
    output logic [3:0]        rdest,
    output logic [3:0]        rsrc,
    output logic [15:0]       imm,
    output logic              imm_sel,
    output logic              branch_taken,
    output logic [15:0]       instr_count
);

    logic              valid;
    logic [3:0]        op;
    logic [3:0]        ext;
    logic [ADDR_W-1:0] pc_next;
    logic              take;

    assign op    = ir[15:12];
    assign ext   = ir[7:4];
    assign rdest = ir[11:8];
    assign rsrc  = ir[3:0];

    // An unloaded IR reports "other" so the control FSM returns to fetch.
    always_comb begin
        instr_type = 2'b00;
        if (!valid) begin
            instr_type = 2'b11;
        end else if (op == 4'b0100) begin
            case (ext)
                4'b0000: instr_type = 2'b10;
                4'b0100: instr_type = 2'b01;
                default: instr_type = 2'b11;
            endcase
        end else if (op == 4'b1100) begin
            instr_type = 2'b11;
        end
    end

    always_comb begin
        case (op)
            4'b0001, 4'b0010, 4'b0011: imm = {8'h00, ir[7:0]};
            4'b1111:                   imm = {ir[7:0], 8'h00};
            default:                   imm = {{8{ir[7]}}, ir[7:0]};
        endcase
    end

    assign imm_sel = !(op inside {4'b0000, 4'b0100, 4'b1000, 4'b1100});

`ifdef FETCH_BRANCH_EN
    logic        cond_true;
    logic [15:0] br_off;

    // flags = {Z,C,F,L,N}
    always_comb begin
        case (ir[11:8])
            4'b0000: cond_true =  flags[4];
            4'b0001: cond_true = !flags[4];
            4'b0010: cond_true =  flags[3];
            4'b0011: cond_true = !flags[3];
            4'b0100: cond_true =  flags[1];
            4'b0101: cond_true = !flags[1];
            4'b0110: cond_true =  flags[0];
            4'b0111: cond_true = !flags[0];
            4'b1000: cond_true =  flags[2];
            4'b1001: cond_true = !flags[2];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign br_off = {{8{ir[7]}}, ir[7:0]};

    always_comb begin
        take    = 1'b0;
        pc_next = pc + ADDR_W'(1);
        if (valid && cond_true) begin
            if (op == 4'b1100) begin
                take    = 1'b1;
                pc_next = pc + br_off[ADDR_W-1:0];
            end else if (op == 4'b0100 && ext == 4'b1100) begin
                take    = 1'b1;
                pc_next = jtarget[ADDR_W-1:0];
            end
        end
    end
`else
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{flags, jtarget};
    assign take                 = 1'b0;
    assign pc_next              = pc + ADDR_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            ir           <= '0;
            valid        <= 1'b0;
            branch_taken <= 1'b0;
            instr_count  <= '0;
        end else begin
            branch_taken <= pc_en && take;
            if (pc_en) begin
                pc          <= pc_next;
                instr_count <= instr_count + 16'd1;
            end
            if (ir_en) begin
                ir    <= mem_rdata;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Upstream front end of the multicycle CPU control path.
- Owns the program counter and the instruction register.
- Decodes the latched instruction into the 2-bit instr_type consumed by the CPU control FSM, plus register/immediate fields for the datapath.
- Advances the PC (sequential or branch/jump) when the FSM pulses pc_en, and captures memory read data when the FSM pulses ir_en.

Parameters:
- ADDR_W, 16, program counter / instruction address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_en  input  1  advance PC this cycle (from FSM PC_enable).
- ir_en  input  1  load IR from mem_rdata this cycle (from FSM IR_enable).
- mem_rdata  input  16  instruction word read from memory at address pc.
- flags  input  5  ALU flag register {Z,C,F,L,N} (bit4..bit0).
- jtarget  input  16  Rsrc register data, used as jump target; low ADDR_W bits used.
- pc  output  ADDR_W  current program counter (memory fetch address).
- ir  output  16  instruction register.
- instr_type  output  2  00 R-type/immediate, 01 STORE, 10 LOAD, 11 other/branch/jump/invalid.
- rdest  output  4  ir[11:8].
- rsrc  output  4  ir[3:0].
- imm  output  16  extended immediate.
- imm_sel  output  1  datapath uses imm instead of Rsrc.
- branch_taken  output  1  one-cycle pulse after a taken branch/jump PC update.
- instr_count  output  16  count of pc_en cycles (retired instructions).

Behaviour:
- Reset (sync, priority over everything): pc=RESET_PC, ir=16'h0000, valid=0, branch_taken=0, instr_count=0.
- IR: on ir_en, ir<=mem_rdata and valid<=1; otherwise hold. Decode outputs are combinational from ir, so they are visible the cycle after the load.
- instr_type = 2'b11 while valid=0, so the FSM loops back to fetch. Otherwise decode on op=ir[15:12], ext=ir[7:4]:
  - op 0100, ext 0000 -> 10 (LOAD).
  - op 0100, ext 0100 -> 01 (STORE).
  - op 0100, any other ext -> 11 (jump/other).
  - op 1100 -> 11 (Bcond).
  - all other op -> 00.
- imm:
  - op 0001/0010/0011 (logical immediates): zero-extend ir[7:0].
  - op 1111 (LUI): {ir[7:0],8'h00}.
  - otherwise: sign-extend ir[7:0].
- imm_sel = 1 unless op is in {0000, 0100, 1000, 1100}.
- Condition code cond=ir[11:8]:
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 L; 0101 !L; 0110 N; 0111 !N; 1000 F; 1001 !F; 1110 always.
  - all others never.
- PC update on pc_en (pc holds the current instruction address, because the FSM loads IR before pc_en):
  - Bcond with cond true (feature on): pc <= pc + sext(ir[7:0]).
  - Jcond (op 0100, ext 1100) with cond true (feature on): pc <= jtarget[ADDR_W-1:0].
  - otherwise: pc <= pc + 1.
  - All arithmetic is modulo 2^ADDR_W; wrap from max to 0 is legal.
- branch_taken: 1 for exactly the cycle after a taken update, else 0.
- instr_count: +1 on every pc_en; wraps at 16'hFFFF -> 0.
- pc_en while valid=0: pc <= pc + 1, never branches.
- Simultaneous pc_en and ir_en: both happen. Branch evaluation uses the old ir; IR captures mem_rdata.
- Reset asserted mid-instruction: state is fully restored to reset values on that edge; in-flight pc_en/ir_en are ignored.

Optional Feature:
- Macro: FETCH_BRANCH_EN.
- Defined: Bcond/Jcond targets are evaluated as described above.
- Undefined: the condition logic and target adders are removed. pc_en always gives pc <= pc + 1, and branch_taken is tied to 0. Decode of instr_type is unchanged.

Test Plan:
- reset high 2 cycles, then low -> pc=0, ir=0, instr_type=11, instr_count=0, branch_taken=0.
- ir_en with mem_rdata=16'h4204, then pc_en -> instr_type=10, rdest=2, rsrc=4, imm_sel=0, pc 0->1, instr_count=1.
- ir_en with 16'h53FE (ADDI) -> instr_type=00, imm=16'hFFFE, imm_sel=1. Then 16'h13FE (ANDI) -> imm=16'h00FE. Then 16'hF312 (LUI) -> imm=16'h1200.
- pc=16'h0010, ir=16'hC0FC (BEQ -4):
  - flags Z=1, pc_en -> pc=16'h000C, branch_taken pulses 1 cycle.
  - repeat with Z=0 -> pc=16'h0011, no pulse.
- ir=16'h4EC3 (JUC), jtarget=16'h0123, pc_en -> pc=16'h0123 with feature defined; pc+1 with it undefined.
- pc=16'hFFFF, non-branch, pc_en -> pc=0. instr_count at 16'hFFFF plus pc_en -> 0. Reset asserted concurrently with pc_en -> pc=RESET_PC.
